// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI4-Lite data-memory slave.
// dpic_pmem_read/dpic_pmem_write keep the LSU's DPI-C signatures (int address,
// int data, byte mask). Here they act on a small package-level word array, so
// the slice elaborates on its own. pmem_wr_count and pmem_last_mask record
// write commits so that they can be observed.
package axi_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_RESP
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT,
    W_RESP
  } wr_state_e;

  // Latency counter width; latencies span 1..15
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam int PMEM_WORDS = 256;

  logic [31:0] pmem_mem [PMEM_WORDS];
  int unsigned pmem_wr_count;
  logic [7:0]  pmem_last_mask;

  // Word-granular read; the low two address bits fall away in the shift
  function automatic int dpic_pmem_read(input int addr);
    return int'(pmem_mem[8'(addr >> 2)]);
  endfunction

  // Byte-masked read-modify-write of one word
  function automatic void dpic_pmem_write(input int addr, input int data, input byte mask);
    logic [31:0] word;
    logic [31:0] din;
    word = pmem_mem[8'(addr >> 2)];
    din  = data;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) word[8*i +: 8] = din[8*i +: 8];
    end
    pmem_mem[8'(addr >> 2)] = word;
    pmem_wr_count  = pmem_wr_count + 1;
    pmem_last_mask = mask;
  endfunction

endpackage

// File: rtl/dmem_lfsr.sv
// 4-bit Galois LFSR, polynomial x^4+x^3+1 (period 15). It steps every cycle
// and returns to SEED on reset. SEED must be nonzero.
module dmem_lfsr #(
  parameter logic [3:0] SEED = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] lfsr
);

  // Shift right and fold the output bit back into taps 3 and 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {1'b0, lfsr[3:1]} ^ (lfsr[0] ? 4'b1100 : 4'b0000);
  end

endmodule

// File: rtl/dmem_sram.sv
// AXI4-Lite-style data-memory slave with a multi-cycle access latency.
// Reads and writes run as independent IDLE/WAIT/RESP machines. Each allows one
// outstanding transaction.
// Optional feature: define DMEM_RAND_DELAY_EN to draw each latency (1..4) from
// a 4-bit LFSR instead of using FIXED_LATENCY.
module dmem_sram
  import axi_pkg::*;
#(
  parameter int         ADDR_WIDTH    = 32,
  parameter int         DATA_WIDTH    = 32,
  parameter int         FIXED_LATENCY = 1,
  parameter logic [3:0] LFSR_SEED     = 4'b1001
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready
);

  if (LFSR_SEED == 4'd0 || FIXED_LATENCY < 1 || FIXED_LATENCY > 15) begin : g_bad_param
    $error("dmem_sram: LFSR_SEED must be nonzero and FIXED_LATENCY within 1..15");
  end

  rd_state_e               rd_state;
  wr_state_e               wr_state;
  logic [CNT_W-1:0]        rd_cnt;
  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        lat;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    aw_captured;
  logic                    w_captured;

`ifdef DMEM_RAND_DELAY_EN
  logic [3:0] lfsr;

  dmem_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  // Read and write share this value when they accept in the same cycle
  assign lat = CNT_ONE + {2'b00, lfsr[1:0]};
`else
  assign lat = CNT_W'(FIXED_LATENCY);
`endif

  assign arready = (rd_state == R_IDLE);
  assign awready = (wr_state == W_IDLE) && !aw_captured;
  assign wready  = (wr_state == W_IDLE) && !w_captured;
  assign rresp   = OKAY;
  assign bresp   = OKAY;

  logic                    ar_fire;
  logic                    aw_fire;
  logic                    w_fire;
  logic                    wr_go;
  logic                    rd_commit;
  logic                    wr_commit;
  logic [ADDR_WIDTH-1:0]   ar_addr_aligned;
  logic [ADDR_WIDTH-1:0]   rd_addr_now;
  logic [ADDR_WIDTH-1:0]   wr_addr_now;
  logic [DATA_WIDTH-1:0]   wr_data_now;
  logic [DATA_WIDTH/8-1:0] wr_strb_now;

  assign ar_fire         = arvalid && arready;
  assign aw_fire         = awvalid && awready;
  assign w_fire          = wvalid && wready;
  assign ar_addr_aligned = {araddr[ADDR_WIDTH-1:2], 2'b00};

  // Both halves of the write are present: either held from earlier or arriving now
  assign wr_go = (wr_state == W_IDLE) && (aw_captured || aw_fire) && (w_captured || w_fire);

  // A latency of 1 commits on the accepting edge itself, so the access uses the live inputs
  assign rd_commit   = (ar_fire && lat == CNT_ONE) || (rd_state == R_WAIT && rd_cnt == CNT_ONE);
  assign wr_commit   = (wr_go && lat == CNT_ONE) || (wr_state == W_WAIT && wr_cnt == CNT_ONE);
  assign rd_addr_now = (rd_state == R_IDLE) ? ar_addr_aligned : rd_addr;
  assign wr_addr_now = aw_captured ? aw_addr : {awaddr[ADDR_WIDTH-1:2], 2'b00};
  assign wr_data_now = w_captured ? w_data : wdata;
  assign wr_strb_now = w_captured ? w_strb : wstrb;

  // Memory commit (write before read, so a same-edge read sees new data) and both channel FSMs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state    <= R_IDLE;
      rd_cnt      <= '0;
      rd_addr     <= '0;
      rdata       <= '0;
      rvalid      <= 1'b0;
      wr_state    <= W_IDLE;
      wr_cnt      <= '0;
      aw_addr     <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      aw_captured <= 1'b0;
      w_captured  <= 1'b0;
      bvalid      <= 1'b0;
    end else begin
      if (wr_commit) dpic_pmem_write(int'(wr_addr_now), int'(wr_data_now), 8'(wr_strb_now));
      if (rd_commit) rdata <= DATA_WIDTH'(dpic_pmem_read(int'(rd_addr_now)));

      case (wr_state)
        W_IDLE: begin
          if (aw_fire) begin
            aw_addr     <= {awaddr[ADDR_WIDTH-1:2], 2'b00};
            aw_captured <= 1'b1;
          end
          if (w_fire) begin
            w_data     <= wdata;
            w_strb     <= wstrb;
            w_captured <= 1'b1;
          end
          if (wr_go) begin
            if (lat == CNT_ONE) begin
              aw_captured <= 1'b0;
              w_captured  <= 1'b0;
              bvalid      <= 1'b1;
              wr_state    <= W_RESP;
            end else begin
              wr_cnt   <= lat - CNT_ONE;
              wr_state <= W_WAIT;
            end
          end
        end
        W_WAIT: begin
          if (wr_cnt == CNT_ONE) begin
            wr_cnt      <= '0;
            aw_captured <= 1'b0;
            w_captured  <= 1'b0;
            bvalid      <= 1'b1;
            wr_state    <= W_RESP;
          end else begin
            wr_cnt <= wr_cnt - CNT_ONE;
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid   <= 1'b0;
            wr_state <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase

      case (rd_state)
        R_IDLE: begin
          if (ar_fire) begin
            rd_addr <= ar_addr_aligned;
            if (lat == CNT_ONE) begin
              rvalid   <= 1'b1;
              rd_state <= R_RESP;
            end else begin
              rd_cnt   <= lat - CNT_ONE;
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_cnt == CNT_ONE) begin
            rd_cnt   <= '0;
            rvalid   <= 1'b1;
            rd_state <= R_RESP;
          end else begin
            rd_cnt <= rd_cnt - CNT_ONE;
          end
        end
        R_RESP: begin
          if (rready) begin
            rvalid   <= 1'b0;
            rd_state <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: doc/dmem_sram.md
# dmem_sram

Data-memory slave sitting directly downstream of the load/store unit. Accepts AXI4-Lite-style read and write transactions, commits them to the simulated physical memory through the `dpic_pmem_read` and `dpic_pmem_write` DPI-C functions, and returns responses after a multi-cycle access latency. Read and write channels are independent state machines. This turns the LSU's single-cycle memory into a realistic handshaked memory.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width. Strobe width is `DATA_WIDTH/8`.
- `FIXED_LATENCY`, 1, access latency in cycles. Legal range 1..15.
- `LFSR_SEED`, 4'b1001, LFSR reset value. Must be nonzero.

Ports. One clock; reset is asynchronous and active-low.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `araddr` in 32: read address.
- `arvalid` in 1.
- `arready` out 1.
- `rdata` out 32: read data.
- `rresp` out 2: always 2'b00 (OKAY).
- `rvalid` out 1.
- `rready` in 1.
- `awaddr` in 32: write address.
- `awvalid` in 1.
- `awready` out 1.
- `wdata` in 32: write data, already lane-shifted by the master.
- `wstrb` in 4: byte enables.
- `wvalid` in 1.
- `wready` out 1.
- `bresp` out 2: always 2'b00 (OKAY).
- `bvalid` out 1.
- `bready` in 1.

## Operation
Read FSM: R_IDLE → R_WAIT → R_RESP.
- R_IDLE:
  - `arready`=1.
  - On `arvalid&&arready`: latch `araddr & ~3`, load the counter with the latency, go to R_WAIT.
- R_WAIT:
  - Counter decrements each cycle.
  - At counter==1: call `dpic_pmem_read(latched addr)`, register the result into `rdata`, go to R_RESP.
- R_RESP:
  - `rvalid`=1; `rdata` is held stable.
  - On `rready`: go to R_IDLE.

Write FSM: W_IDLE → W_WAIT → W_RESP.
- W_IDLE:
  - `awready`=!aw_captured and `wready`=!w_captured.
  - AW and W may arrive in either order or together. Each is latched on its own handshake.
  - Once both are captured (the same cycle counts): load the counter, go to W_WAIT.
- W_WAIT:
  - At counter==1: call `dpic_pmem_write(addr & ~3, wdata, {4'b0, wstrb})`, clear both captured flags, go to W_RESP.
- W_RESP:
  - `bvalid`=1.
  - On `bready`: go to W_IDLE.

General rules:
- Address bits [1:0] are ignored. Lane placement is the master's job.
- `wstrb`=0 is still a legal transaction: DPI is called with a zero mask and the B response is still returned.
- Read and write commit in the same cycle: the write DPI call executes before the read call. A same-address read therefore returns the new data.
- At most one outstanding read and one outstanding write. No new AR/AW is accepted until the matching response handshake completes.

## Timing
- Reset values (asynchronous): both FSMs in IDLE, counters 0, captured flags 0.
  - `arready`=1, `awready`=1, `wready`=1.
  - `rvalid`=0, `bvalid`=0.
  - `rdata`=0, `rresp`=0, `bresp`=0.
- Read latency: with an AR handshake in cycle N, `rvalid` rises at edge N+L, where L is the latency (default 1 → next cycle).
- Write latency: `bvalid` rises L cycles after the cycle in which the second of AW/W is captured.
- Throughput: with `rready` held high, one read every L+1 cycles. The AR for the next read is accepted the cycle after the R handshake.
- Response valid is held until ready. Data and resp do not change while valid and !ready.
- Reset mid-transaction: the transaction is dropped with no response. A write whose DPI call has not yet executed is not committed.
- Ready signals are decoded from state (combinational). Valid signals and data are registered.

## Configuration
- `DMEM_RAND_DELAY_EN` defined:
  - L is 1 + lfsr[1:0], giving 1..4, sampled at each request acceptance.
  - The LFSR is 4 bits, x^4+x^3+1, advances every cycle, and resets to `LFSR_SEED`.
  - Read and write sample the same LFSR value if they accept in the same cycle.
- Undefined: L = `FIXED_LATENCY` and no LFSR is instantiated.

## Structure
- Shared package `axi_pkg`:
  - `axi_resp_e` (OKAY=2'b00, SLVERR=2'b10).
  - `rd_state_e` and `wr_state_e` enums.
  - Latency counter width constant (4 bits).
- DPI imports match the existing LSU signatures: int address, int data, byte mask.
- Sub-module `dmem_lfsr`: 4-bit Galois LFSR with a seed parameter, async reset, output `lfsr[3:0]`. Instantiated only under `DMEM_RAND_DELAY_EN`.

## Test plan
- Reset, then single read of 0x8000_0000 holding 0xDEADBEEF, L=1: `rvalid` one cycle after AR, `rdata`=0xDEADBEEF, `rresp`=0.
- Write 0x8000_0004 with data 0x0000_AB00 and `wstrb`=4'b0010, W presented 3 cycles before AW: exactly one DPI write with mask 8'h02 after both are captured; a subsequent read returns byte 1 = 0xAB and the other bytes unchanged.
- `rready` held low 5 cycles after `rvalid`: `rvalid`/`rdata` stable throughout; `arready`=0 until the R handshake completes.
- Read and write to the same address, committing in the same cycle (FIXED_LATENCY=3): the read returns the newly written data; both B and R responses are OKAY.
- `rst_n` asserted while in W_WAIT: no DPI write issued, `bvalid`=0, all readies =1 immediately.
- With `DMEM_RAND_DELAY_EN` and seed 4'b1001, 20 back-to-back reads: every latency is in 1..4, and the latency sequence matches the golden LFSR model.
